// File: rtl/cnn_pkg.sv
// Shared CNN datapath package.
// Holds the FP32 word geometry, the conv1 feature-map dimensions and the
// float ReLU helper shared by the streaming layer stages.
package cnn_pkg;

    localparam int FP_DW    = 32;
    localparam int FP_SIGN  = 31;
    localparam int CONV1_CH = 32;
    localparam int CONV1_W  = 28;
    localparam int CONV1_H  = 28;

    // Any word with the sign bit set (negatives, -0.0, negative NaN) becomes +0.0.
    function automatic logic [FP_DW-1:0] fp_relu(input logic [FP_DW-1:0] word);
        return word[FP_SIGN] ? '0 : word;
    endfunction

endpackage

// File: rtl/relu_max2.sv
// One-lane combinational ReLU + max.
// Ports: a, b - raw float words; y - max(relu(a), relu(b)).
// After ReLU both operands are non-negative IEEE words, so an unsigned integer
// compare orders them correctly, with +Inf and positive NaN ranking highest.
module relu_max2 import cnn_pkg::*; #(
    parameter int DW = FP_DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    logic [DW-1:0] ra;
    logic [DW-1:0] rb;

    assign ra = a[DW-1] ? '0 : a;
    assign rb = b[DW-1] ? '0 : b;
    assign y  = (ra > rb) ? ra : rb;

endmodule

// File: rtl/relu_maxpool1.sv
// Streaming ReLU + 2x2/stride-2 max-pool after conv1.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   in_valid, in_sof - beat qualifier, start-of-frame (only meaningful with in_valid)
//   in_data          - one pixel, channel c at [c*DW +: DW]
//   out_valid        - one-cycle pulse per pooled pixel
//   out_data         - pooled pixel (held between pulses)
//   frame_done       - pulses with the last pooled pixel of a frame
// Even columns park the pixel in hold; odd columns fold it into a horizontal
// pair max. Even rows bank that pair in linebuf, odd rows combine with the
// banked pair and emit. Trailing odd column/row never reaches an emit slot.
module relu_maxpool1 import cnn_pkg::*; #(
    parameter int CH    = CONV1_CH,
    parameter int DW    = FP_DW,
    parameter int IMG_W = CONV1_W,
    parameter int IMG_H = CONV1_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [CH*DW-1:0] in_data,
    output logic             out_valid,
    output logic [CH*DW-1:0] out_data,
    output logic             frame_done
);

    localparam int NP = IMG_W / 2;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LW = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_PLAST = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_PLAST = RW'(2 * (IMG_H / 2) - 1);

    logic [CW-1:0]    col, cur_col;
    logic [RW-1:0]    row, cur_row;
    logic [CH*DW-1:0] hold, hold_d, pmax, pool, lb_rd;
    logic [CH*DW-1:0] linebuf [NP];
    logic [LW-1:0]    lb_idx;
    logic             fire, fire_last, lb_we;

    // SOF simply relabels this beat as (0,0); whatever was in flight is
    // abandoned because nothing downstream of it can reach an emit slot.
    assign cur_col = in_sof ? '0 : col;
    assign cur_row = in_sof ? '0 : row;
    assign lb_idx  = LW'(cur_col >> 1);
    assign lb_rd   = linebuf[lb_idx];

    assign fire      = in_valid && cur_row[0] && cur_col[0];
    assign fire_last = fire && (cur_row == ROW_PLAST) && (cur_col == COL_PLAST);
    assign lb_we     = in_valid && cur_col[0] && !cur_row[0];

    for (genvar c = 0; c < CH; c++) begin : g_lane
        assign hold_d[c*DW +: DW] = fp_relu(in_data[c*DW +: DW]);

        relu_max2 #(.DW(DW)) u_pmax (
            .a (hold[c*DW +: DW]),
            .b (in_data[c*DW +: DW]),
            .y (pmax[c*DW +: DW])
        );

        relu_max2 #(.DW(DW)) u_pool (
            .a (pmax[c*DW +: DW]),
            .b (lb_rd[c*DW +: DW]),
            .y (pool[c*DW +: DW])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= fire;
            frame_done <= fire_last;
            if (fire)
                out_data <= pool;
            if (in_valid) begin
                if (!cur_col[0])
                    hold <= hold_d;
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

    // Every entry is rewritten on each even row before the odd row reads it,
    // so the line buffer needs no reset or frame clear.
    always_ff @(posedge clk) begin
        if (lb_we)
            linebuf[lb_idx] <= pmax;
    end

endmodule

// File: tb/tb_relu_maxpool1.sv
// Randomized self-checking bench for relu_maxpool1.
// Two DUTs: index 0 is 4x4, index 1 is 5x5. The reference keeps the whole
// received frame in an array and computes each pooled pixel directly from
// its 2x2 window when the completing beat is driven.
module tb_relu_maxpool1;

    localparam int CH = 32;
    localparam int DW = 32;
    localparam int N  = CH * DW;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [2];
    logic         isof [2];
    logic [N-1:0] idat [2];
    logic         ov   [2];
    logic [N-1:0] od   [2];
    logic         fd   [2];

    int errors = 0;
    int checks = 0;

    int           pr [2];
    int           pc [2];
    logic [N-1:0] frm [2][5][5];
    logic [N-1:0] last_out [2];
    int           nouts [2];
    logic [N-1:0] outs_q [$];

    always #5 clk = ~clk;

    relu_maxpool1 #(.CH(CH), .DW(DW), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_sof(isof[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_data(od[0]), .frame_done(fd[0])
    );

    relu_maxpool1 #(.CH(CH), .DW(DW), .IMG_W(5), .IMG_H(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_sof(isof[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_data(od[1]), .frame_done(fd[1])
    );

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            int ch;
            ch = 0;
            for (int i = CH - 1; i >= 0; i--)
                if (got[i*DW +: DW] !== exp[i*DW +: DW]) ch = i;
            errors++;
            $display("FAIL %s ch%0d got=%h exp=%h", tag, ch, got[ch*DW +: DW], exp[ch*DW +: DW]);
        end
    endtask

    function automatic int dim(input int s);
        return (s == 0) ? 4 : 5;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] w);
        return w[31] ? 32'h0 : w;
    endfunction

    // Max of the four ReLU'd pixels of the window whose bottom-right is (r,c).
    function automatic logic [N-1:0] gold(input int s, input int r, input int c);
        logic [N-1:0] g;
        logic [31:0]  w, m;
        g = '0;
        for (int ch = 0; ch < CH; ch++) begin
            m = 32'h0;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    w = relu(frm[s][r-1+dr][c-1+dc][ch*DW +: DW]);
                    if (w > m) m = w;
                end
            g[ch*DW +: DW] = m;
        end
        return g;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h7F800000;
            1:       return 32'hFFC00000;
            2:       return 32'h80000000;
            3:       return 32'h00000000;
            4:       return 32'h7FC00001;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [N-1:0] rand_pix();
        logic [N-1:0] p;
        for (int ch = 0; ch < CH; ch++) p[ch*DW +: DW] = rand_word();
        return p;
    endfunction

    task automatic beat(input int s, input logic sof, input logic [N-1:0] d);
        int  w, h;
        logic ev, efd;
        w = dim(s);
        h = dim(s);
        iv[s]   = 1'b1;
        isof[s] = sof;
        idat[s] = d;
        if (sof) begin pr[s] = 0; pc[s] = 0; end
        frm[s][pr[s]][pc[s]] = d;
        ev  = (pr[s] % 2 == 1) && (pc[s] % 2 == 1) && (pr[s] < 2*(h/2)) && (pc[s] < 2*(w/2));
        efd = ev && (pr[s] == 2*(h/2) - 1) && (pc[s] == 2*(w/2) - 1);
        if (ev) begin
            last_out[s] = gold(s, pr[s], pc[s]);
            nouts[s]++;
            outs_q.push_back(last_out[s]);
        end
        pc[s]++;
        if (pc[s] == w) begin
            pc[s] = 0;
            pr[s]++;
            if (pr[s] == h) pr[s] = 0;
        end
        @(posedge clk);
        #1;
        iv[s]   = 1'b0;
        isof[s] = 1'b0;
        chk("valid", N'(ov[s]), N'(ev));
        chk("frame_done", N'(fd[s]), N'(efd));
        chk("data", od[s], last_out[s]);
    endtask

    task automatic idle(input int s);
        @(posedge clk);
        #1;
        chk("idle_valid", N'(ov[s]), '0);
        chk("idle_fdone", N'(fd[s]), '0);
        chk("idle_hold", od[s], last_out[s]);
    endtask

    // One full frame of random pixels; gap_pct sets the chance of an idle
    // cycle before each beat.
    task automatic rand_frame(input int s, input int gap_pct, input logic sof_first);
        int n0;
        n0 = nouts[s];
        for (int i = 0; i < dim(s) * dim(s); i++) begin
            while ($urandom_range(0, 99) < gap_pct) idle(s);
            beat(s, sof_first && (i == 0), rand_pix());
        end
        chk("frame_nout", N'(nouts[s] - n0), N'((dim(s)/2) * (dim(s)/2)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        for (int s = 0; s < 2; s++) begin
            chk("rst_async_valid", N'(ov[s]), '0);
            chk("rst_async_data", od[s], '0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("rst_valid", N'(ov[s]), '0);
            chk("rst_fdone", N'(fd[s]), '0);
            chk("rst_data", od[s], '0);
            pr[s] = 0;
            pc[s] = 0;
            last_out[s] = '0;
        end
    endtask

    initial begin
        logic [N-1:0] one, two, px;
        int n0;
        one = {CH{32'h3F800000}};
        two = {CH{32'h40000000}};
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; isof[s] = 1'b0; idat[s] = '0; nouts[s] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1.0 everywhere except 2.0 at (1,1)
        outs_q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                beat(0, 1'b0, (r == 1 && c == 1) ? two : one);
        chk("t1_out0", outs_q[0], two);
        chk("t1_out1", outs_q[1], one);
        chk("t1_out3", outs_q[3], one);

        // all negatives / negative zero
        outs_q.delete();
        for (int i = 0; i < 16; i++)
            beat(0, 1'b0, (i % 3 == 0) ? {CH{32'h80000000}} : {CH{32'hBF800000}});
        chk("t2_neg_zero", outs_q[0], '0);

        // +Inf vs 1.0 vs negative NaN vs 0 on channel 5
        outs_q.delete();
        for (int i = 0; i < 16; i++) begin
            px = '0;
            if (i == 0) px[5*DW +: DW] = 32'h7F800000;
            if (i == 1) px[5*DW +: DW] = 32'h3F800000;
            if (i == 4) px[5*DW +: DW] = 32'hFFC00000;
            beat(0, i == 0, px);
        end
        px = outs_q[0];
        chk("t3_inf", N'(px[5*DW +: DW]), N'(32'h7F800000));

        // random frames, gapless then ~50% gaps
        rand_frame(0, 0, 1'b1);
        for (int f = 0; f < 3; f++) rand_frame(0, 50, 1'b0);

        // SOF abort at (2,1): nothing from the aborted tail, full new frame
        for (int i = 0; i < 9; i++) beat(0, 1'b0, rand_pix());
        n0 = nouts[0];
        rand_frame(0, 30, 1'b1);
        chk("t5_sof_nout", N'(nouts[0] - n0), N'(4));

        // 5x5 ramp then random: trailing row/col ignored
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                for (int ch = 0; ch < CH; ch++)
                    px[ch*DW +: DW] = 32'h3F800000 + 32'((r * 5 + c) * 256 + ch);
                beat(1, r == 0 && c == 0, px);
            end
        for (int f = 0; f < 2; f++) rand_frame(1, 40, 1'b0);

        // reset in the middle of row 1, then a frame without SOF
        for (int i = 0; i < 6; i++) beat(0, 1'b0, rand_pix());
        do_reset();
        idle(0);
        rand_frame(0, 20, 1'b0);
        rand_frame(1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
